hit_scorer: RTL and testbench

HIT_SCORER -- requirements
Module: hit_scorer

---
 rtl/hit_scorer_if.sv | 34 +++
 rtl/hit_scorer.sv | 188 ++++++++++++++++++
 tb/tb_hit_scorer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hit_scorer_if.sv
// Frame-evaluation bus for hit_scorer: snapshot inputs, per-block clear strobes,
// running score/miss totals and FSM visibility.
interface hit_scorer_if #(
    parameter int NUM_BLOCKS = 5
);
    // Protocol: a falling edge on vs requests one frame evaluation; busy is high
    // from SNAP through UPDATE and further vs edges are dropped while busy.
    // block_clear and hit_valid are single-cycle strobes during the UPDATE cycle
    // (there is no backpressure), and score_bcd/miss_count change one cycle later.
    logic                         vs;
    logic [19:0]                  ball_x;
    logic [19:0]                  ball_y;
    logic [19:0]                  ball_s;
    logic [NUM_BLOCKS*10-1:0]     block_x;
    logic [NUM_BLOCKS*10-1:0]     block_y;
    logic [NUM_BLOCKS*10-1:0]     block_s;
    logic [NUM_BLOCKS-1:0]        block_ready;
    logic [NUM_BLOCKS-1:0]        block_clear;
    logic                         hit_valid;
    logic [15:0]                  score_bcd;
    logic [7:0]                   miss_count;
    logic                         busy;
    logic [1:0]                   dbg_state;

    modport master (
        output vs, ball_x, ball_y, ball_s, block_x, block_y, block_s, block_ready,
        input  block_clear, hit_valid, score_bcd, miss_count, busy, dbg_state
    );

    modport slave (
        input  vs, ball_x, ball_y, ball_s, block_x, block_y, block_s, block_ready,
        output block_clear, hit_valid, score_bcd, miss_count, busy, dbg_state
    );
endinterface

// File: rtl/hit_scorer.sv
// Per-frame ball/block collision scorer: snapshots positions on vs falling edge,
// scans one ball/block pair per cycle, then clears hit/missed blocks and updates totals.
module hit_scorer #(
    parameter int NUM_BLOCKS    = 5,
    parameter int SCREEN_BOTTOM = 479
) (
    input  logic       Clk,
    input  logic       Reset,
    hit_scorer_if.slave bus
);
    localparam int NPAIR = 2 * NUM_BLOCKS;
    localparam int PW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam int KW    = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam logic [10:0] BOTTOM = 11'(SCREEN_BOTTOM);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SNAP   = 2'd1,
        SCAN   = 2'd2,
        UPDATE = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_vs;
    logic                  r_vs_prev;
    logic [9:0]            r_ball_x [2];
    logic [9:0]            r_ball_y [2];
    logic [9:0]            r_ball_s [2];
    logic [9:0]            r_blk_x  [NUM_BLOCKS];
    logic [9:0]            r_blk_y  [NUM_BLOCKS];
    logic [9:0]            r_blk_s  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] r_ready;
    logic [NUM_BLOCKS-1:0] r_hit;
    logic [NUM_BLOCKS-1:0] r_block_clear;
    logic                  r_hit_valid;
    logic [PW-1:0]         r_pair;
    logic [15:0]           r_score;
    logic [7:0]            r_miss;

    logic                  w_fall;
    logic [KW-1:0]         w_k;
    logic                  w_b;
    logic [9:0]            w_bx, w_by, w_bs, w_kx, w_ky, w_ks;
    logic [9:0]            w_dx, w_dy;
    logic [10:0]           w_lim;
    logic                  w_collide;
    logic [NUM_BLOCKS-1:0] w_hit_nxt;
    logic [NUM_BLOCKS-1:0] w_bottom;
    logic [NUM_BLOCKS-1:0] w_miss_scan;
    logic [NUM_BLOCKS-1:0] w_miss_upd;
    logic [7:0]            w_hit_cnt;
    logic [7:0]            w_miss_cnt;
    logic [8:0]            w_carry;
    logic [8:0]            w_digit_sum;
    logic [15:0]           w_score_sum;
    logic [15:0]           w_score_nxt;
    logic [8:0]            w_miss_sum;
    logic [7:0]            w_miss_nxt;

    function automatic logic [7:0] popcount(input logic [NUM_BLOCKS-1:0] v);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) c = c + {7'd0, v[i]};
        return c;
    endfunction

    assign w_fall = r_vs_prev & ~r_vs;
    assign w_k    = KW'(r_pair >> 1);
    assign w_b    = r_pair[0];

    // Distances and limits are kept one bit wider so large half-sizes never wrap.
    always_comb begin
        w_bx = r_ball_x[w_b];
        w_by = r_ball_y[w_b];
        w_bs = r_ball_s[w_b];
        w_kx = r_blk_x[w_k];
        w_ky = r_blk_y[w_k];
        w_ks = r_blk_s[w_k];
        w_dx = (w_bx >= w_kx) ? (w_bx - w_kx) : (w_kx - w_bx);
        w_dy = (w_by >= w_ky) ? (w_by - w_ky) : (w_ky - w_by);
        w_lim = {1'b0, w_bs} + {1'b0, w_ks};
        w_collide = r_ready[w_k] & ({1'b0, w_dx} <= w_lim) & ({1'b0, w_dy} <= w_lim);
        w_hit_nxt = r_hit;
        if (w_collide) w_hit_nxt[w_k] = 1'b1;
    end

    always_comb begin
        w_bottom = '0;
        for (int k = 0; k < NUM_BLOCKS; k++) begin
            w_bottom[k] = (({1'b0, r_blk_y[k]} + {1'b0, r_blk_s[k]}) >= BOTTOM);
        end
        w_miss_scan = r_ready & ~w_hit_nxt & w_bottom;
        w_miss_upd  = r_ready & ~r_hit & w_bottom;
    end

    // Score is added digit by digit; a carry out of the top digit means saturate.
    always_comb begin
        w_hit_cnt   = popcount(r_hit);
        w_miss_cnt  = popcount(w_miss_upd);
        w_carry     = {1'b0, w_hit_cnt};
        w_digit_sum = '0;
        w_score_sum = '0;
        for (int d = 0; d < 4; d++) begin
            w_digit_sum = {5'd0, r_score[4*d +: 4]} + w_carry;
            w_score_sum[4*d +: 4] = 4'(w_digit_sum % 9'd10);
            w_carry = w_digit_sum / 9'd10;
        end
        w_score_nxt = (w_carry != 9'd0) ? 16'h9999 : w_score_sum;
        w_miss_sum  = {1'b0, r_miss} + {1'b0, w_miss_cnt};
        w_miss_nxt  = w_miss_sum[8] ? 8'hFF : w_miss_sum[7:0];
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state       <= IDLE;
            r_vs          <= 1'b1;
            r_vs_prev     <= 1'b1;
            r_ready       <= '0;
            r_hit         <= '0;
            r_block_clear <= '0;
            r_hit_valid   <= 1'b0;
            r_pair        <= '0;
            r_score       <= '0;
            r_miss        <= '0;
            for (int b = 0; b < 2; b++) begin
                r_ball_x[b] <= '0;
                r_ball_y[b] <= '0;
                r_ball_s[b] <= '0;
            end
            for (int k = 0; k < NUM_BLOCKS; k++) begin
                r_blk_x[k] <= '0;
                r_blk_y[k] <= '0;
                r_blk_s[k] <= '0;
            end
        end else begin
            r_vs          <= bus.vs;
            r_vs_prev     <= r_vs;
            r_block_clear <= '0;
            r_hit_valid   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fall) r_state <= SNAP;
                end
                SNAP: begin
                    for (int b = 0; b < 2; b++) begin
                        r_ball_x[b] <= bus.ball_x[b*10 +: 10];
                        r_ball_y[b] <= bus.ball_y[b*10 +: 10];
                        r_ball_s[b] <= bus.ball_s[b*10 +: 10];
                    end
                    for (int k = 0; k < NUM_BLOCKS; k++) begin
                        r_blk_x[k] <= bus.block_x[k*10 +: 10];
                        r_blk_y[k] <= bus.block_y[k*10 +: 10];
                        r_blk_s[k] <= bus.block_s[k*10 +: 10];
                    end
                    r_ready <= bus.block_ready;
                    r_hit   <= '0;
                    r_pair  <= '0;
                    r_state <= SCAN;
                end
                SCAN: begin
                    r_hit <= w_hit_nxt;
                    // The last pair's result is folded in here so the strobes land in UPDATE.
                    if (r_pair == PW'(NPAIR - 1)) begin
                        r_block_clear <= w_hit_nxt | w_miss_scan;
                        r_hit_valid   <= |w_hit_nxt;
                        r_state       <= UPDATE;
                    end else begin
                        r_pair <= r_pair + 1'b1;
                    end
                end
                UPDATE: begin
                    r_score <= w_score_nxt;
                    r_miss  <= w_miss_nxt;
                    r_hit   <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.block_clear = r_block_clear;
    assign bus.hit_valid   = r_hit_valid;
    assign bus.score_bcd   = r_score;
    assign bus.miss_count  = r_miss;
    assign bus.busy        = (r_state != IDLE);
    assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_hit_scorer.sv
// Bench for hit_scorer: directed and random frames, a reference model that pushes
// expected frame results into a queue, and a monitor that checks each UPDATE.
module tb_hit_scorer;
    localparam int NB = 5;
    localparam int SB = 479;
    localparam int EW = NB + 1 + 16 + 8;

    logic clk = 1'b0;
    logic rst_n;
    always #10 clk = ~clk;

    hit_scorer_if #(.NUM_BLOCKS(NB)) bus ();
    hit_scorer #(.NUM_BLOCKS(NB), .SCREEN_BOTTOM(SB)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    int n_pass = 0;
    int n_total = 0;
    logic [EW-1:0] exp_q[$];
    int bx[2], by[2], bs[2];
    int kx[NB], ky[NB], ks[NB];
    bit rdy[NB];
    int m_score, m_miss;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    // Reference: a block is hit if any ball box overlaps it; misses need an unhit
    // active block reaching the bottom line; totals saturate at 9999 and 255.
    task automatic push_expected();
        logic [NB-1:0] clr;
        int nh, nm;
        clr = '0;
        nh = 0;
        nm = 0;
        for (int k = 0; k < NB; k++) begin
            bit hit, miss;
            hit = 0;
            if (rdy[k]) begin
                for (int b = 0; b < 2; b++) begin
                    int lim;
                    lim = bs[b] + ks[k];
                    if (iabs(bx[b] - kx[k]) <= lim && iabs(by[b] - ky[k]) <= lim) hit = 1;
                end
            end
            miss = rdy[k] && !hit && (ky[k] + ks[k] >= SB);
            clr[k] = hit || miss;
            if (hit) nh++;
            if (miss) nm++;
        end
        m_score = (m_score + nh > 9999) ? 9999 : m_score + nh;
        m_miss  = (m_miss + nm > 255) ? 255 : m_miss + nm;
        exp_q.push_back({clr, (nh > 0) ? 1'b1 : 1'b0, to_bcd(m_score), 8'(m_miss)});
    endtask

    task automatic apply_inputs();
        for (int b = 0; b < 2; b++) begin
            bus.ball_x[b*10 +: 10] = 10'(bx[b]);
            bus.ball_y[b*10 +: 10] = 10'(by[b]);
            bus.ball_s[b*10 +: 10] = 10'(bs[b]);
        end
        for (int k = 0; k < NB; k++) begin
            bus.block_x[k*10 +: 10] = 10'(kx[k]);
            bus.block_y[k*10 +: 10] = 10'(ky[k]);
            bus.block_s[k*10 +: 10] = 10'(ks[k]);
            bus.block_ready[k] = rdy[k];
        end
    endtask

    task automatic clear_scene();
        for (int b = 0; b < 2; b++) begin
            bx[b] = 1000; by[b] = 10; bs[b] = 1;
        end
        for (int k = 0; k < NB; k++) begin
            kx[k] = 10 + 40 * k; ky[k] = 10; ks[k] = 1; rdy[k] = 0;
        end
    endtask

    task automatic random_scene();
        for (int b = 0; b < 2; b++) begin
            bx[b] = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(200, 280);
            by[b] = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(200, 280);
            bs[b] = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 1023) : $urandom_range(1, 15);
        end
        for (int k = 0; k < NB; k++) begin
            kx[k] = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(200, 280);
            ky[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(440, 530) : $urandom_range(200, 280);
            ks[k] = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 1023) : $urandom_range(1, 15);
            rdy[k] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic pulse_vs();
        bus.vs = 1'b0;
        tick();
        bus.vs = 1'b1;
    endtask

    task automatic wait_frame();
        int t;
        t = 0;
        while (!bus.busy && t < 20) begin tick(); t++; end
        while (bus.busy && t < 60) begin tick(); t++; end
        chk("frame_done", (t >= 20 && !bus.busy && t < 60) || (t < 20) ? 32'd0 : 32'd1, 32'd0);
        tick();
    endtask

    task automatic run_frame();
        apply_inputs();
        push_expected();
        pulse_vs();
        wait_frame();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_clear"}, 32'(bus.block_clear), 32'd0);
        chk({tag, "_hit_valid"}, 32'(bus.hit_valid), 32'd0);
        chk({tag, "_score"}, 32'(bus.score_bcd), 32'd0);
        chk({tag, "_miss"}, 32'(bus.miss_count), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        check_reset_state("reset");
        m_score = 0;
        m_miss = 0;
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic single_hit_scene();
        clear_scene();
        bx[0] = 100; by[0] = 200; bs[0] = 4;
        rdy[2] = 1; kx[2] = 104; ky[2] = 205; ks[2] = 4;
    endtask

    task automatic sat_hit_scene(input int nact);
        clear_scene();
        bx[0] = 500; by[0] = 300; bs[0] = 5;
        for (int k = 0; k < NB; k++) begin
            kx[k] = 500; ky[k] = 300; ks[k] = 5; rdy[k] = (k < nact);
        end
    endtask

    // Monitor: each busy run must last SNAP+SCAN+UPDATE cycles, with strobes only
    // in its final cycle; totals are checked in the first idle cycle after it.
    logic [NB-1:0] mon_clr;
    logic          mon_hv;
    int            mon_run;
    logic          mon_prev_busy;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_run = 0; mon_prev_busy = 1'b0; mon_clr = '0; mon_hv = 1'b0;
        end else begin
            if (bus.busy) begin
                if (mon_run > 0) chk("no_early_pulse", 32'({mon_clr, mon_hv}), 32'd0);
                mon_run++;
                mon_clr = bus.block_clear;
                mon_hv  = bus.hit_valid;
            end else begin
                if (mon_prev_busy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        logic [EW-1:0] e;
                        e = exp_q.pop_front();
                        chk("latency", 32'(mon_run), 32'(2 * NB + 2));
                        chk("block_clear", 32'(mon_clr), 32'(e[EW-1 -: NB]));
                        chk("hit_valid", 32'(mon_hv), 32'(e[24]));
                        chk("score_bcd", 32'(bus.score_bcd), 32'(e[23:8]));
                        chk("miss_count", 32'(bus.miss_count), 32'(e[7:0]));
                    end
                    mon_run = 0;
                end
                chk("idle_no_pulse", 32'({bus.block_clear, bus.hit_valid}), 32'd0);
            end
            mon_prev_busy = bus.busy;
        end
    end

    initial begin
        int cnt, t, guard;
        rst_n = 1'b0;
        bus.vs = 1'b1;
        m_score = 0;
        m_miss = 0;
        clear_scene();
        apply_inputs();
        repeat (3) tick();
        check_reset_state("initial");
        rst_n = 1'b1;
        repeat (2) tick();

        single_hit_scene();
        run_frame();

        clear_scene();
        bx[0] = 300; by[0] = 300; bs[0] = 5;
        bx[1] = 305; by[1] = 302; bs[1] = 5;
        rdy[0] = 1; kx[0] = 302; ky[0] = 301; ks[0] = 3;
        run_frame();

        clear_scene();
        bx[0] = 900; by[0] = 100; bx[1] = 900; by[1] = 120;
        rdy[4] = 1; kx[4] = 50; ky[4] = 470; ks[4] = 10;
        run_frame();

        clear_scene();
        bx[0] = 300; by[0] = 300; bs[0] = 5;
        rdy[0] = 1; kx[0] = 308; ky[0] = 300; ks[0] = 3;
        rdy[1] = 1; kx[1] = 300; ky[1] = 309; ks[1] = 3;
        rdy[2] = 1; kx[2] = 50;  ky[2] = 469; ks[2] = 10;
        rdy[3] = 1; kx[3] = 90;  ky[3] = 468; ks[3] = 10;
        rdy[4] = 0; kx[4] = 600; ky[4] = 500; ks[4] = 10;
        run_frame();

        clear_scene();
        bx[0] = 5; by[0] = 5; bs[0] = 700;
        rdy[0] = 1; kx[0] = 1020; ky[0] = 5; ks[0] = 400;
        run_frame();

        do_reset();
        for (int i = 0; i < 19; i++) begin
            sat_hit_scene(5);
            run_frame();
        end
        sat_hit_scene(4);
        run_frame();
        sat_hit_scene(1);
        run_frame();

        for (int i = 0; i < 40; i++) begin
            random_scene();
            run_frame();
        end

        random_scene();
        apply_inputs();
        push_expected();
        pulse_vs();
        t = 0;
        while (!bus.busy && t < 20) begin tick(); t++; end
        repeat (3) tick();
        random_scene();
        apply_inputs();
        pulse_vs();
        wait_frame();
        repeat (20) tick();

        single_hit_scene();
        apply_inputs();
        pulse_vs();
        cnt = 0;
        t = 0;
        while (cnt < 7 && t < 40) begin
            tick();
            t++;
            if (bus.busy) cnt++;
        end
        chk("abort_reached_scan", 32'(cnt), 32'd7);
        do_reset();
        repeat (20) tick();
        single_hit_scene();
        run_frame();

        clear_scene();
        for (int k = 0; k < NB; k++) begin
            rdy[k] = 1; kx[k] = 100 + 80 * k; ky[k] = 470; ks[k] = 10;
        end
        guard = 0;
        while (m_miss < 255 && guard < 100) begin
            run_frame();
            guard++;
        end
        run_frame();

        sat_hit_scene(5);
        guard = 0;
        while (m_score < 9999 && guard < 2100) begin
            run_frame();
            guard++;
        end
        run_frame();
        sat_hit_scene(1);
        run_frame();

        repeat (5) tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
